// File: rtl/restoring_div_ctrl.sv
// restoring_div_ctrl: multi-cycle unsigned restoring divider.
// Computes Dividend / Divisor one quotient bit per clock behind a Go/Busy/Done
// handshake. Quotient and Remainder are registered and hold between completions.
// Optional feature macro: DIVZERO_DETECT_EN adds the DivByZero output and a
// one-cycle bypass for a zero divisor.
module restoring_div_ctrl #(
  parameter int N = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Go,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Busy,
  output logic         Done
`ifdef DIVZERO_DETECT_EN
  ,
  output logic         DivByZero
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_r, state_s;
  logic [N:0]      a_r, a_s;
  logic [N-1:0]    q_r, q_s;
  logic [N-1:0]    m_r, m_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [N-1:0]    quot_s, rem_s;
  logic            busy_s, done_s;
  logic [N:0]      a_sh_s, t_s;
  logic [N-1:0]    q_sh_s;
`ifdef DIVZERO_DETECT_EN
  logic            dz_r, dz_s;
`endif

  // Next-state, datapath iteration and next output values.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    q_s     = q_r;
    m_s     = m_r;
    cnt_s   = cnt_r;
    quot_s  = Quotient;
    rem_s   = Remainder;
`ifdef DIVZERO_DETECT_EN
    dz_s    = dz_r;
`endif
    // {A,Q} shifted left by one, then trial subtraction of the divisor.
    a_sh_s  = {a_r[N-1:0], q_r[N-1]};
    q_sh_s  = {q_r[N-2:0], 1'b0};
    t_s     = a_sh_s - {1'b0, m_r};

    case (state_r)
      IDLE: begin
        if (Go) begin
`ifdef DIVZERO_DETECT_EN
          if (Divisor == {N{1'b0}}) begin
            // Zero divisor skips the iterations and reports immediately.
            state_s = DONE;
            quot_s  = {N{1'b1}};
            rem_s   = Dividend;
            dz_s    = 1'b1;
          end else begin
            q_s     = Dividend;
            m_s     = Divisor;
            a_s     = {(N+1){1'b0}};
            cnt_s   = CW'(N);
            state_s = RUN;
          end
`else
          q_s     = Dividend;
          m_s     = Divisor;
          a_s     = {(N+1){1'b0}};
          cnt_s   = CW'(N);
          state_s = RUN;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (t_s[N]) begin
          // Negative trial result: keep the shifted A, quotient bit 0.
          a_s = a_sh_s;
          q_s = q_sh_s;
        end else begin
          a_s = t_s;
          q_s = {q_r[N-2:0], 1'b1};
        end
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_s = DONE;
          quot_s  = q_s;
          rem_s   = a_s[N-1:0];
`ifdef DIVZERO_DETECT_EN
          dz_s    = 1'b0;
`endif
        end else begin
          state_s = RUN;
        end
      end
      // Go is not sampled here, so a held Go restarts only once IDLE is reached.
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r   <= IDLE;
      a_r       <= {(N+1){1'b0}};
      q_r       <= {N{1'b0}};
      m_r       <= {N{1'b0}};
      cnt_r     <= {CW{1'b0}};
      Quotient  <= {N{1'b0}};
      Remainder <= {N{1'b0}};
      Busy      <= 1'b0;
      Done      <= 1'b0;
`ifdef DIVZERO_DETECT_EN
      dz_r      <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      q_r       <= q_s;
      m_r       <= m_s;
      cnt_r     <= cnt_s;
      Quotient  <= quot_s;
      Remainder <= rem_s;
      Busy      <= busy_s;
      Done      <= done_s;
`ifdef DIVZERO_DETECT_EN
      dz_r      <= dz_s;
`endif
    end
  end

`ifdef DIVZERO_DETECT_EN
  assign DivByZero = dz_r;
`endif

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Self-checking bench for restoring_div_ctrl (N=4) using a scoreboard queue.
module tb_restoring_div_ctrl;
  localparam int N = 4;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         Go = 1'b0;
  logic [N-1:0] Dividend = '0;
  logic [N-1:0] Divisor = '0;
  logic [N-1:0] Quotient, Remainder;
  logic         Busy, Done;
`ifdef DIVZERO_DETECT_EN
  logic         DivByZero;
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  restoring_div_ctrl #(.N(N)) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Go(Go),
    .Dividend(Dividend),
    .Divisor(Divisor),
    .Quotient(Quotient),
    .Remainder(Remainder),
    .Busy(Busy),
    .Done(Done)
`ifdef DIVZERO_DETECT_EN
    ,
    .DivByZero(DivByZero)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           go_cyc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cycle = 0;
  int           done_cnt = 0;
  int           push_cnt = 0;
  logic [N-1:0] last_q = '0;
  logic [N-1:0] last_r = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Posedge counter; latency is counted in edges after the edge that samples Go.
  always @(posedge Clock) cycle <= cycle + 1;

  // Output monitor: score every Done, otherwise results must hold while busy.
  always @(negedge Clock) begin : mon
    exp_t e;
    if (Resetn && Done) begin
      done_cnt++;
      chk("busy_with_done", Busy, 1);
      chk("done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("quotient", Quotient, e.q);
        chk("remainder", Remainder, e.r);
        chk("latency", cycle - e.go_cyc, e.dz ? 0 : N);
`ifdef DIVZERO_DETECT_EN
        chk("divbyzero", DivByZero, e.dz);
`endif
        last_q = e.q;
        last_r = e.r;
      end
    end else if (Resetn && Busy) begin
      chk("hold_q", Quotient, last_q);
      chk("hold_r", Remainder, last_r);
    end
  end

  task automatic push_exp(input logic [N-1:0] dd, input logic [N-1:0] dv);
    exp_t e;
    e.q      = (dv == 0) ? {N{1'b1}} : dd / dv;
    e.r      = (dv == 0) ? dd : dd % dv;
    e.dz     = DZ_EN && (dv == 0);
    e.go_cyc = cycle + 1;
    sb.push_back(e);
    push_cnt++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((Busy || Done) && n < 50) begin
      @(negedge Clock);
      n++;
    end
    chk("idle_timeout", Busy || Done, 0);
  endtask

  task automatic start_div(input logic [N-1:0] dd, input logic [N-1:0] dv, input bit keep_go);
    wait_idle();
    Go       = 1'b1;
    Dividend = dd;
    Divisor  = dv;
    push_exp(dd, dv);
    @(negedge Clock);
    if (!keep_go) Go = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || Busy) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    // Reset state
    #12;
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);

    // 7 / 2
    start_div(4'd7, 4'd2, 1'b0);
    drain();
    chk("t1_q", Quotient, 3);
    chk("t1_r", Remainder, 1);

    // Full sweep with non-zero divisors
    for (int dd = 0; dd < 16; dd++)
      for (int dv = 1; dv < 16; dv++)
        start_div(dd[N-1:0], dv[N-1:0], 1'b0);
    drain();

    // 9 / 3 with Go held and Dividend changed mid-run
    start_div(4'd9, 4'd3, 1'b1);
    Dividend = 4'd15;
    n = 0;
    while (!Done && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk("t3_done_seen", Done, 1);
    @(negedge Clock);
    chk("t3_idle_after_done", Busy, 0);
    // Go still high: the next edge starts 15 / 3.
    push_exp(4'd15, 4'd3);
    @(negedge Clock);
    chk("t3_restart_busy", Busy, 1);
    Go = 1'b0;
    drain();
    chk("t3_q", Quotient, 5);
    chk("t3_r", Remainder, 0);
    chk("t3_one_done_per_req", done_cnt, push_cnt);

    // 13 / 0
    start_div(4'd13, 4'd0, 1'b0);
    drain();
    chk("t4_q", Quotient, 15);
    chk("t4_r", Remainder, 13);

    // 14 / 4 aborted by reset between edges 2 and 3
    start_div(4'd14, 4'd4, 1'b0);
    @(posedge Clock);
    @(posedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    chk("t5_rst_q", Quotient, 0);
    chk("t5_rst_r", Remainder, 0);
    chk("t5_rst_busy", Busy, 0);
    chk("t5_rst_done", Done, 0);
    sb.delete();
    push_cnt--;
    last_q = '0;
    last_r = '0;
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (8) @(negedge Clock);
    chk("t5_idle", Busy, 0);
    chk("t5_no_done", done_cnt, push_cnt);
    start_div(4'd3, 4'd5, 1'b0);
    drain();
    chk("t5_q", Quotient, 0);
    chk("t5_r", Remainder, 3);
    chk("done_count", done_cnt, push_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
